// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: left-to-right square-and-multiply driving
// one external Montgomery multiplier (R = 2^64) over a GO/ready handshake.
module mod_exp_ctrl #(
  parameter int unsigned EXP_W = 64
) (
  input  logic             pclk,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [63:0]      base,
  input  logic [EXP_W-1:0] exp,
  input  logic [63:0]      mod_m,
  input  logic [63:0]      r2_mod,
  output logic [63:0]      result,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             mm_go,
  output logic [63:0]      mm_a,
  output logic [63:0]      mm_b,
  output logic [63:0]      mm_m,
  input  logic [63:0]      mm_p,
  input  logic             mm_ready
);

  localparam int unsigned IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_TO_B,
    OP_TO_X,
    OP_SQ,
    OP_MUL,
    OP_FROM
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [63:0]      base_q, base_d;
  logic [63:0]      r2_q, r2_d;
  logic [63:0]      bm_q, bm_d;
  logic [63:0]      x_q, x_d;
  logic [63:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             mm_go_q, mm_go_d;
  logic [63:0]      mm_a_q, mm_a_d;
  logic [63:0]      mm_b_q, mm_b_d;
  logic [63:0]      mm_m_q, mm_m_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    base_d   = base_q;
    r2_d     = r2_q;
    bm_d     = bm_q;
    x_d      = x_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    busy_d   = busy_q;
    mm_go_d  = mm_go_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    mm_m_d   = mm_m_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          base_d = base;
          exp_d  = exp;
          r2_d   = r2_mod;
          mm_m_d = mod_m;
          err_d  = 1'b0;
          busy_d = 1'b1;
          op_d   = OP_TO_B;
          if (!mod_m[0]) begin
            err_d    = 1'b1;
            result_d = '0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      // Operands are loaded on the same edge that raises GO, so they never
      // move while GO is high.
      S_GAP: begin
        mm_go_d = 1'b1;
        state_d = S_RUN;
        unique case (op_q)
          OP_TO_B: begin mm_a_d = base_q; mm_b_d = r2_q;  end
          OP_TO_X: begin mm_a_d = 64'd1;  mm_b_d = r2_q;  end
          OP_SQ:   begin mm_a_d = x_q;    mm_b_d = x_q;   end
          OP_MUL:  begin mm_a_d = x_q;    mm_b_d = bm_q;  end
          OP_FROM: begin mm_a_d = x_q;    mm_b_d = 64'd1; end
          default: begin mm_a_d = x_q;    mm_b_d = x_q;   end
        endcase
      end

      S_RUN: begin
        if (mm_go_q && mm_ready) begin
          mm_go_d = 1'b0;
          state_d = S_GAP;
          unique case (op_q)
            OP_TO_B: begin
              bm_d = mm_p;
              op_d = OP_TO_X;
            end
            OP_TO_X: begin
              x_d   = mm_p;
              op_d  = OP_SQ;
              idx_d = IW'(EXP_W - 1);
            end
            OP_SQ: begin
              x_d = mm_p;
              if (exp_q[idx_q]) begin
                op_d = OP_MUL;
              end else if (idx_q == '0) begin
                op_d = OP_FROM;
              end else begin
                idx_d = idx_q - IW'(1);
              end
            end
            OP_MUL: begin
              x_d = mm_p;
              if (idx_q == '0) begin
                op_d = OP_FROM;
              end else begin
                idx_d = idx_q - IW'(1);
                op_d  = OP_SQ;
              end
            end
            OP_FROM: begin
              result_d = mm_p;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over any capture in the same cycle, including the final one.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      mm_go_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_TO_B;
      idx_q    <= '0;
      exp_q    <= '0;
      base_q   <= '0;
      r2_q     <= '0;
      bm_q     <= '0;
      x_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mm_go_q  <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      mm_m_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      base_q   <= base_d;
      r2_q     <= r2_d;
      bm_q     <= bm_d;
      x_q      <= x_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      mm_go_q  <= mm_go_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
      mm_m_q   <= mm_m_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign mm_go  = mm_go_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_m   = mm_m_q;

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
Sequencer that computes base^exp mod M by driving a Montgomery multiplier (R = 2^64) through its GO/is_ready handshake. It is the initiator side of that interface: it presents operands, holds GO, waits for ready, captures the product, then releases GO. It runs left-to-right square-and-multiply with Montgomery domain entry and exit. It sits between the APB register file, which supplies operands and the precomputed r2_mod = 2^128 mod M, and one multiplier instance.

Parameters:
EXP_W, 64, number of exponent bits processed, MSB first (1..64).

Ports:
pclk  in  1  clock
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE, no done pulse
base  in  64  base, must be < M
exp  in  EXP_W  exponent
mod_m  in  64  modulus; must be odd and < 2^63
r2_mod  in  64  2^128 mod M, supplied by software
result  out  64  base^exp mod M; valid when done pulses; held until next accepted start
done  out  1  one-cycle pulse on completion
err  out  1  set with done when mod_m is even; cleared on next accepted start
busy  out  1  high from the cycle after an accepted start until done or abort
mm_go  out  1  multiplier GO; held high for the whole operation
mm_a  out  64  multiplier operand A; stable while mm_go is high
mm_b  out  64  multiplier operand B; stable while mm_go is high
mm_m  out  64  multiplier modulus (latched mod_m)
mm_p  in  64  multiplier product
mm_ready  in  1  multiplier is_ready

Behaviour:
- Reset (async, nreset low): state IDLE; result, done, err, busy, mm_go, mm_a, mm_b, mm_m and all internal registers are 0.
- Accepted start (IDLE and start=1): latch base, exp, mod_m, r2_mod; clear err; set busy. If latched mod_m[0]=0, go directly to DONE with err=1 and result=0.
- Op handshake, used by every multiply:
  - OP: drive mm_a/mm_b, assert mm_go.
  - Wait until mm_ready=1 is sampled while mm_go=1. Capture mm_p in the same cycle.
  - GAP: mm_go=0 for exactly one cycle, so the multiplier clears its ready before the next op.
  - mm_ready is ignored whenever mm_go=0.
- States and ops in order:
  - IDLE.
  - TO_B: a=base, b=r2 -> bm.
  - TO_X: a=1, b=r2 -> x.
  - Then i from EXP_W-1 down to 0:
    - SQ: a=x, b=x -> x.
    - If exp[i]=1, MUL: a=x, b=bm -> x.
  - FROM: a=x, b=1 -> result.
  - DONE: pulse done for one cycle, return to IDLE.
- Op count per run: 3 + EXP_W + popcount(exp). No leading-zero skip.
- Bit index is a down-counter. It decrements after the SQ op when exp[i]=0, otherwise after the MUL op. The FROM op follows the op at i=0.
- abort in any non-IDLE state: next cycle mm_go=0, busy=0, state IDLE; result keeps its prior value; no done.
  - abort and start together in IDLE: start is ignored.
- start while busy is ignored; latched operands are unchanged.
- mm_a, mm_b and mm_m change only in OP-entry or GAP cycles, never while mm_go=1.
- exp=0: result = 1 mod M (0 when M=1).

Test Plan:
- base=3, exp=5, M=7, r2=4, EXP_W=64 -> result=5, err=0. mm_go rising edges = 69. done pulses exactly one cycle.
- base=2, exp=10, M=1000003, r2 from bench model -> result=1024. Scoreboard matches a bignum reference over 200 random odd M<2^63, base<M, exp.
- exp=0, base=5, M=7 -> result=1 after 67 ops. With M=1 -> result=0.
- M=8 -> done at the cycle after start, err=1, result=0, mm_go never asserted.
- start pulsed during SQ -> ignored, result unchanged. abort during a MUL op -> mm_go low next cycle, busy=0, no done. A subsequent run with base=3, exp=5, M=7 still returns 5.
- Assert nreset low while mm_go=1 -> all outputs 0 immediately (async). Multiplier model checks operands are stable while mm_go=1, and that there is at least one mm_go-low cycle between ops.
